// File: rtl/cs_window_param_if.sv
// Sample/result bundle for cs_window_param: sample-side controls in, windowed sum out.
interface cs_window_param_if #(
  parameter int DW = 8,
  parameter int OW = 10
);
  logic [DW-1:0] X;
  logic          in_valid;
  logic          flush;
  logic          mode;
  logic [OW-1:0] Y;
  logic          out_valid;

  modport master (output X, in_valid, flush, mode, input Y, out_valid);
  modport slave  (input X, in_valid, flush, mode, output Y, out_valid);
endinterface

// File: rtl/cs_window_param.sv
// N-deep sliding-window approximate-average sum; Y/out_valid register on the accepting edge.
// No backpressure: one sample per cycle, in_valid=0 cycles leave the window untouched.
module cs_window_param #(
  parameter int DW    = 8,
  parameter int N     = 9,
  parameter int SHIFT = 3,
  parameter int OW    = 10
) (
  input  logic clk,
  input  logic reset,
  cs_window_param_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int SW = DW + $clog2(N);
  localparam int TW = SW + 1;
  localparam longint MAXY = (2 * longint'(N) * ((longint'(1) << DW) - 1)) >> SHIFT;

  generate
    if (N < 2 || N > 32) begin : g_bad_n
      $error("cs_window_param: N must be in 2..32");
    end
    if ((longint'(1) << OW) <= MAXY) begin : g_bad_ow
      $error("cs_window_param: OW too narrow for the largest result");
    end
  endgenerate

  logic [DW-1:0] r_win [N];
  logic [SW-1:0] r_sum;
  logic [CW-1:0] r_fill;
  logic [OW-1:0] r_y;
  logic          r_ov;

  logic [DW-1:0] w_win [N];
  logic [SW-1:0] w_sum;
  logic [DW-1:0] w_appr;
  logic [TW-1:0] w_tot;
  logic [OW-1:0] w_y;
  logic [CW-1:0] w_fill_nxt;
  logic          w_full_nxt;

  // Window as it will look after this edge's shift; r_win[N-1] is the sample dropped.
  always_comb begin
    w_win[0] = bus.X;
    for (int i = 1; i < N; i++) w_win[i] = r_win[i-1];
  end

  assign w_sum = r_sum + SW'(bus.X) - SW'(r_win[N-1]);

  // Largest sample not above the average; the minimum always qualifies.
  always_comb begin
    w_appr = '0;
    for (int i = 0; i < N; i++) begin
      if ((TW'(w_win[i]) * TW'(N) <= TW'(w_sum)) && (w_win[i] > w_appr))
        w_appr = w_win[i];
    end
  end

  always_comb begin
    w_tot = '0;
    if (bus.mode) w_tot = {w_sum, 1'b0};
    else          w_tot = TW'(w_sum) + TW'(w_appr) * TW'(N);
  end

  assign w_y        = OW'(w_tot >> SHIFT);
  assign w_fill_nxt = (r_fill == CW'(N)) ? r_fill : r_fill + CW'(1);
  assign w_full_nxt = (w_fill_nxt == CW'(N));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_win[i] <= '0;
      r_sum  <= '0;
      r_fill <= '0;
      r_y    <= '0;
      r_ov   <= 1'b0;
    end else if (bus.flush) begin
      for (int i = 0; i < N; i++) r_win[i] <= '0;
      r_sum  <= '0;
      r_fill <= '0;
      r_y    <= '0;
      r_ov   <= 1'b0;
    end else if (bus.in_valid) begin
      for (int i = 0; i < N; i++) r_win[i] <= w_win[i];
      r_sum  <= w_sum;
      r_fill <= w_fill_nxt;
      r_ov   <= w_full_nxt;
      if (w_full_nxt) r_y <= w_y;
    end else begin
      r_ov <= 1'b0;
    end
  end

  assign bus.Y         = r_y;
  assign bus.out_valid = r_ov;
endmodule

// File: tb/tb_cs_window_param.sv
// Directed bench for cs_window_param: default-parameter table plus N=5 and async-reset sequences.
module tb_cs_window_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cs_window_param_if #(.DW(8), .OW(10)) bus_a ();
  // OW=9 with N=5, SHIFT=2 only holds for samples of 7 bits or fewer.
  cs_window_param_if #(.DW(7), .OW(9))  bus_b ();

  cs_window_param #(.DW(8), .N(9), .SHIFT(3), .OW(10)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  cs_window_param #(.DW(7), .N(5), .SHIFT(2), .OW(9)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  typedef struct {
    logic [7:0] x;
    logic       vld;
    logic       fl;
    logic       md;
    logic [9:0] ey;
    logic       eov;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int x, bit vld, bit fl, bit md, int ey, bit eov);
    vec_t v;
    v.x = 8'(x); v.vld = vld; v.fl = fl; v.md = md; v.ey = 10'(ey); v.eov = eov;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  task automatic push_a(int x, bit vld, bit fl, bit md);
    @(negedge clk);
    bus_a.X = 8'(x); bus_a.in_valid = vld; bus_a.flush = fl; bus_a.mode = md;
    @(posedge clk);
    #1;
  endtask

  task automatic push_b(int x, bit vld);
    @(negedge clk);
    bus_b.X = 7'(x); bus_b.in_valid = vld; bus_b.flush = 1'b0; bus_b.mode = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_a.X = '0; bus_a.in_valid = 1'b0; bus_a.flush = 1'b0; bus_a.mode = 1'b0;
    bus_b.X = '0; bus_b.in_valid = 1'b0; bus_b.flush = 1'b0; bus_b.mode = 1'b0;

    // Fill 1..9 then slide with 10, a gap, then flush with a colliding sample.
    for (int i = 1; i <= 9; i++) add(i, 1, 0, 0, (i == 9) ? 11 : 0, i == 9);
    add(10, 1, 0, 0, 13, 1);
    add(0, 0, 0, 0, 13, 0);
    add(55, 1, 1, 0, 0, 0);
    // Alternating valid: same result as the gap-free fill, needs a full refill after flush.
    for (int i = 1; i <= 9; i++) begin
      add(i, 1, 0, 0, (i == 9) ? 11 : 0, i == 9);
      add(77, 0, 0, 0, (i == 9) ? 11 : 0, 0);
    end
    add(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 0, 0);
    add(100, 1, 0, 0, 12, 1);
    add(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 1, 0, 0);
    add(100, 1, 0, 1, 25, 1);
    add(0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) add(255, 1, 0, 0, (i == 9) ? 573 : 0, i == 9);

    #3;
    check("reset_y_a", int'(bus_a.Y), 0);
    check("reset_ov_a", int'(bus_a.out_valid), 0);
    check("reset_y_b", int'(bus_b.Y), 0);
    check("reset_ov_b", int'(bus_b.out_valid), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      push_a(int'(tbl[k].x), tbl[k].vld, tbl[k].fl, tbl[k].md);
      check($sformatf("vec%0d_y", k), int'(bus_a.Y), int'(tbl[k].ey));
      check($sformatf("vec%0d_ov", k), int'(bus_a.out_valid), int'(tbl[k].eov));
    end

    // Async reset between edges with a valid sample still on the inputs.
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_y", int'(bus_a.Y), 0);
    check("async_rst_ov", int'(bus_a.out_valid), 0);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      push_a(i, 1, 0, 0);
      check($sformatf("refill%0d_ov", i), int'(bus_a.out_valid), (i == 9) ? 1 : 0);
      check($sformatf("refill%0d_y", i), int'(bus_a.Y), (i == 9) ? 11 : 0);
    end
    push_a(0, 0, 0, 0);
    check("refill_gap_ov", int'(bus_a.out_valid), 0);

    // N=5, SHIFT=2: 1..5 gives 30>>2 = 7; sliding in 6 gives window 2..6, (20+20)>>2 = 10.
    for (int i = 1; i <= 5; i++) begin
      push_b(i, 1);
      check($sformatf("n5_fill%0d_ov", i), int'(bus_b.out_valid), (i == 5) ? 1 : 0);
      check($sformatf("n5_fill%0d_y", i), int'(bus_b.Y), (i == 5) ? 7 : 0);
    end
    push_b(6, 1);
    check("n5_slide_y", int'(bus_b.Y), 10);
    check("n5_slide_ov", int'(bus_b.out_valid), 1);
    push_b(0, 0);
    check("n5_gap_ov", int'(bus_b.out_valid), 0);
    check("n5_gap_y", int'(bus_b.Y), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
